// File: rtl/pkt_tx_framer.sv
// Transmit packet framer: gathers PKT_BYTES SPI bytes, then serialises preamble, sync word and payload MSB-first on bit_en.
// Optional CRC-8 (poly 0x07) trailer after the payload when PKT_TX_CRC_EN is defined.
module pkt_tx_framer #(
    parameter int                      PKT_BYTES    = 8,
    parameter int                      PREAMBLE_LEN = 8,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE     = 8'hAA,
    parameter logic [7:0]              SYNC_WORD    = 8'hD3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_vld,
    input  logic       bit_en,
    input  logic       abort,
    output logic       byte_rdy,
    output logic       busy,
    output logic       dout,
    output logic       pkt_done,
    output logic       ovf
);

    localparam int PAY_BITS = 8 * PKT_BYTES;
    localparam int CNT_MAX  = (PAY_BITS > PREAMBLE_LEN) ? PAY_BITS : ((PREAMBLE_LEN > 8) ? PREAMBLE_LEN : 8);
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int BCW      = $clog2(PKT_BYTES + 1);

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(PKT_BYTES - 1);
    localparam logic [CW-1:0]  PRE_LAST  = CW'(PREAMBLE_LEN);
    localparam logic [CW-1:0]  SYNC_LAST = CW'(8);
    localparam logic [CW-1:0]  PAY_LAST  = CW'(PAY_BITS);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FILL = 3'd1;
    localparam logic [2:0] ST_ARM  = 3'd2;
    localparam logic [2:0] ST_PRE  = 3'd3;
    localparam logic [2:0] ST_SYNC = 3'd4;
    localparam logic [2:0] ST_PAY  = 3'd5;
`ifdef PKT_TX_CRC_EN
    localparam logic [2:0] ST_CRC  = 3'd6;
`endif

    logic [2:0]              state;
    logic [PAY_BITS-1:0]     pkt_reg;
    logic [BCW-1:0]          byte_cnt;
    logic [CW-1:0]           bit_cnt;
    logic [PREAMBLE_LEN-1:0] pre_sh;
    logic [7:0]              sync_sh;
    logic                    in_tx;

`ifdef PKT_TX_CRC_EN
    logic [7:0] crc;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        crc_step = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    assign in_tx = (state != ST_IDLE) && (state != ST_FILL);

    // Bytes arrive MSB-byte first, so shifting each one in from the bottom
    // leaves the first byte in the top slot once the register is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pkt_reg  <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            pre_sh   <= '0;
            sync_sh  <= '0;
            dout     <= 1'b0;
            busy     <= 1'b0;
            pkt_done <= 1'b0;
            ovf      <= 1'b0;
            byte_rdy <= 1'b1;
`ifdef PKT_TX_CRC_EN
            crc      <= '0;
`endif
        end else begin
            pkt_done <= 1'b0;
            ovf      <= 1'b0;
            if (abort) begin
                state    <= ST_IDLE;
                pkt_reg  <= '0;
                byte_cnt <= '0;
                bit_cnt  <= '0;
                pre_sh   <= '0;
                sync_sh  <= '0;
                dout     <= 1'b0;
                busy     <= 1'b0;
                byte_rdy <= 1'b1;
`ifdef PKT_TX_CRC_EN
                crc      <= '0;
`endif
            end else begin
                ovf <= byte_vld && in_tx;
                case (state)
                    ST_IDLE, ST_FILL: begin
                        if (byte_vld) begin
                            pkt_reg  <= (pkt_reg << 8) | PAY_BITS'(byte_in);
                            byte_cnt <= byte_cnt + 1'b1;
                            if (byte_cnt == LAST_BYTE) begin
                                state    <= ST_ARM;
                                byte_rdy <= 1'b0;
                                busy     <= 1'b1;
                            end else begin
                                state <= ST_FILL;
                            end
                        end
                    end
                    ST_ARM: begin
                        if (bit_en) begin
                            dout    <= PREAMBLE[PREAMBLE_LEN-1];
                            pre_sh  <= PREAMBLE << 1;
                            bit_cnt <= CW'(1);
                            state   <= ST_PRE;
                        end
                    end
                    ST_PRE: begin
                        if (bit_en) begin
                            if (bit_cnt != PRE_LAST) begin
                                dout    <= pre_sh[PREAMBLE_LEN-1];
                                pre_sh  <= pre_sh << 1;
                                bit_cnt <= bit_cnt + 1'b1;
                            end else begin
                                dout    <= SYNC_WORD[7];
                                sync_sh <= SYNC_WORD << 1;
                                bit_cnt <= CW'(1);
                                state   <= ST_SYNC;
                            end
                        end
                    end
                    ST_SYNC: begin
                        if (bit_en) begin
                            if (bit_cnt != SYNC_LAST) begin
                                dout    <= sync_sh[7];
                                sync_sh <= sync_sh << 1;
                                bit_cnt <= bit_cnt + 1'b1;
                            end else begin
                                dout    <= pkt_reg[PAY_BITS-1];
                                pkt_reg <= pkt_reg << 1;
                                bit_cnt <= CW'(1);
                                state   <= ST_PAY;
`ifdef PKT_TX_CRC_EN
                                crc     <= crc_step(crc, pkt_reg[PAY_BITS-1]);
`endif
                            end
                        end
                    end
                    ST_PAY: begin
                        if (bit_en) begin
                            if (bit_cnt != PAY_LAST) begin
                                dout    <= pkt_reg[PAY_BITS-1];
                                pkt_reg <= pkt_reg << 1;
                                bit_cnt <= bit_cnt + 1'b1;
`ifdef PKT_TX_CRC_EN
                                crc     <= crc_step(crc, pkt_reg[PAY_BITS-1]);
`endif
                            end else begin
`ifdef PKT_TX_CRC_EN
                                dout    <= crc[7];
                                crc     <= crc << 1;
                                bit_cnt <= CW'(1);
                                state   <= ST_CRC;
`else
                                state    <= ST_IDLE;
                                pkt_reg  <= '0;
                                byte_cnt <= '0;
                                bit_cnt  <= '0;
                                dout     <= 1'b0;
                                busy     <= 1'b0;
                                byte_rdy <= 1'b1;
                                pkt_done <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef PKT_TX_CRC_EN
                    // The CRC register is shifted out in place once the payload is done.
                    ST_CRC: begin
                        if (bit_en) begin
                            if (bit_cnt != SYNC_LAST) begin
                                dout    <= crc[7];
                                crc     <= crc << 1;
                                bit_cnt <= bit_cnt + 1'b1;
                            end else begin
                                state    <= ST_IDLE;
                                pkt_reg  <= '0;
                                byte_cnt <= '0;
                                bit_cnt  <= '0;
                                crc      <= '0;
                                dout     <= 1'b0;
                                busy     <= 1'b0;
                                byte_rdy <= 1'b1;
                                pkt_done <= 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        state    <= ST_IDLE;
                        dout     <= 1'b0;
                        busy     <= 1'b0;
                        byte_rdy <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pkt_tx_framer.sv
// Directed bench for pkt_tx_framer: full packets, overflow, aborts, ARM hold, async reset and optional CRC trailer.
module tb_pkt_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_vld;
    logic       bit_en;
    logic       abort;
    logic       byte_rdy;
    logic       busy;
    logic       dout;
    logic       pkt_done;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    pkt_tx_framer dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_vld(byte_vld),
        .bit_en(bit_en), .abort(abort), .byte_rdy(byte_rdy), .busy(busy),
        .dout(dout), .pkt_done(pkt_done), .ovf(ovf)
    );

    always #5 clk = ~clk;

`ifdef PKT_TX_CRC_EN
    localparam int NBITS = 88;
`else
    localparam int NBITS = 80;
`endif

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock with the given inputs held, then sample just after the edge.
    task automatic applyStimulus(input logic vld, input logic [7:0] b, input logic be, input logic ab);
        byte_vld = vld;
        byte_in  = b;
        bit_en   = be;
        abort    = ab;
        @(posedge clk);
        #1;
        byte_vld = 1'b0;
        bit_en   = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic loadBytes(input logic [63:0] data, input int n, input logic be);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, data[63-8*i -: 8], be, 1'b0);
    endtask

    function automatic logic [7:0] crcRef(input logic [63:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 63; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [127:0] expStream(input logic [63:0] payload);
`ifdef PKT_TX_CRC_EN
        return {40'b0, 8'hAA, 8'hD3, payload, crcRef(payload)};
`else
        return {48'b0, 8'hAA, 8'hD3, payload};
`endif
    endfunction

    // Bit_en every 4 clk; optionally inject a stray byte before bit index ovfAt.
    task automatic runPacket(input string tag, input logic [63:0] payload, input int ovfAt);
        logic [127:0] cap;
        int doneSeen, busyLow, ovfSeen;
        cap = '0; doneSeen = 0; busyLow = 0; ovfSeen = 0;
        for (int i = 0; i < NBITS; i++) begin
            for (int k = 0; k < 3; k++) begin
                applyStimulus((i == ovfAt) && (k == 0), 8'hFF, 1'b0, 1'b0);
                if (pkt_done) doneSeen++;
                if (!busy) busyLow++;
                if (ovf) ovfSeen++;
            end
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            cap = {cap[126:0], dout};
            if (pkt_done) doneSeen++;
            if (!busy) busyLow++;
            if (ovf) ovfSeen++;
        end
        checkOutput({tag, " stream"}, cap, expStream(payload));
        checkOutput({tag, " early done"}, 128'(doneSeen), 128'd0);
        checkOutput({tag, " busy low"}, 128'(busyLow), 128'd0);
        checkOutput({tag, " ovf pulses"}, 128'(ovfSeen), (ovfAt >= 0) ? 128'd1 : 128'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput({tag, " pkt_done"}, 128'(pkt_done), 128'd1);
        checkOutput({tag, " end dout"}, 128'(dout), 128'd0);
        checkOutput({tag, " end busy"}, 128'(busy), 128'd0);
        checkOutput({tag, " end byte_rdy"}, 128'(byte_rdy), 128'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput({tag, " done pulse width"}, 128'(pkt_done), 128'd0);
    endtask

    initial begin
        int bad;
        rst = 1'b1; byte_in = '0; byte_vld = 1'b0; bit_en = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset outputs", {123'b0, dout, busy, pkt_done, ovf, byte_rdy}, 128'b00001);
        rst = 1'b0;

        // Bytes with bit_en in the same cycles: bytes land, bits are ignored in FILL.
        loadBytes(64'h0102030405060708, 7, 1'b1);
        checkOutput("fill byte_rdy", 128'(byte_rdy), 128'd1);
        checkOutput("fill busy/dout", {126'b0, busy, dout}, 128'd0);
        applyStimulus(1'b1, 8'h08, 1'b0, 1'b0);
        checkOutput("arm flags", {125'b0, byte_rdy, busy, dout}, 128'b010);
        bad = 0;
        repeat (100) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            if (dout || !busy || byte_rdy) bad++;
        end
        checkOutput("arm hold", 128'(bad), 128'd0);
        runPacket("pkt1", 64'h0102030405060708, -1);

        loadBytes(64'h0102030405060708, 8, 1'b0);
        runPacket("pkt ovf", 64'h0102030405060708, 20);

        loadBytes(64'h1122334455000000, 5, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("fill abort", {125'b0, byte_rdy, busy, pkt_done}, 128'b100);
        loadBytes(64'hF0F0F0F0F0F0F0F0, 8, 1'b0);
        runPacket("pkt F0", 64'hF0F0F0F0F0F0F0F0, -1);

        // Abort together with the 20th bit_en and a stray byte.
        loadBytes(64'h0102030405060708, 8, 1'b0);
        for (int i = 0; i < 19; i++) begin
            repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
        checkOutput("tx abort", {123'b0, dout, busy, pkt_done, ovf, byte_rdy}, 128'b00001);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 8'h00, (i % 4) == 3, 1'b0);
            if (pkt_done || dout || busy) bad++;
        end
        checkOutput("after abort quiet", 128'(bad), 128'd0);

        // Async reset while dout is high.
        loadBytes(64'h0102030405060708, 8, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("first preamble bit", 128'(dout), 128'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset", {125'b0, dout, busy, byte_rdy}, 128'b001);
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset no done", 128'(pkt_done), 128'd0);

        loadBytes(64'h3132333435363738, 8, 1'b0);
        runPacket("pkt crc", 64'h3132333435363738, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pkt_tx_framer.md
Name: pkt_tx_framer

Overview:
- Transmit-side packet framer: counterpart of the RX shift-buffer/packet-register path.
- Collects PKT_BYTES bytes written over SPI into a packet register. Serialises them MSB-first onto the RF output as preamble, then sync word, then payload, paced by the bit-rate strobe.
- Sits between the SPI slave byte output and the TX output OR-gate in TOP; replaces the single-byte TX buffer for full-packet transmit.

Parameters:
- PKT_BYTES, 8, payload bytes per packet (payload bits = 8*PKT_BYTES).
- PREAMBLE_LEN, 8, preamble length in bits.
- PREAMBLE, 8'hAA, preamble pattern, sent MSB-first; width PREAMBLE_LEN.
- SYNC_WORD, 8'hD3, sync pattern, sent MSB-first after the preamble; width 8.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- byte_in  input  8  byte from the SPI slave.
- byte_vld  input  1  one-cycle strobe: byte_in valid.
- bit_en  input  1  one-cycle bit-rate strobe (synchronised shift-enable).
- abort  input  1  synchronous abort/flush.
- byte_rdy  output  1  framer accepts bytes (FILL/IDLE).
- busy  output  1  high from first ARM cycle until packet end.
- dout  output  1  serial TX data; idles 0.
- pkt_done  output  1  one-cycle pulse at end of packet.
- ovf  output  1  one-cycle pulse when byte_vld arrives while byte_rdy=0.

Behaviour:
- Reset values (async on rst=1): state IDLE, packet register 0, byte count 0, bit count 0, dout=0, busy=0, pkt_done=0, ovf=0, byte_rdy=1.
- States: IDLE, FILL, ARM, PRE, SYNC, PAY[, CRC]. All outputs are registered.
- IDLE: byte_rdy=1. On byte_vld, store byte into bits [8*PKT_BYTES-1 -: 8], set count=1, go to FILL.
- FILL: byte_rdy=1. Each byte_vld stores the byte at the next-lower byte slot (first byte is the MSB byte) and increments count. When the byte making count==PKT_BYTES is stored, go to ARM in the next cycle; byte_rdy drops that same next cycle.
- ARM: busy=1, dout=0. Wait for bit_en.
  - On the bit_en, dout <= PREAMBLE MSB, bit count=1, go to PRE.
- Bit timing: the state and dout change only on cycles with bit_en=1. dout holds between strobes. bit_en in any non-transmit state is ignored.
- PRE: on each bit_en, drive the next preamble bit. After PREAMBLE_LEN bits have been driven, the next bit_en drives SYNC_WORD[7] and moves to SYNC.
- SYNC: same scheme. The bit_en after the 8th sync bit drives payload MSB and moves to PAY.
- PAY: payload bits are driven MSB-first.
  - The bit_en after the last payload bit sets dout=0, pulses pkt_done, sets busy=0, clears the register and counts, and returns to IDLE.
- Bit_en count from ARM to pkt_done = PREAMBLE_LEN + 8 + 8*PKT_BYTES + 1. This is 81 at the defaults.
- Overflow: byte_vld while in ARM, PRE, SYNC, PAY or CRC pulses ovf for one cycle. The byte is dropped and transmission is unaffected.
- abort: highest priority in every state. Next cycle: state IDLE, dout=0, busy=0, counts and register cleared, no pkt_done.
  - abort and byte_vld in the same cycle: the byte is dropped and ovf stays 0.
- byte_vld and bit_en in the same cycle: both take effect independently. Bytes can only land in IDLE/FILL; bits are only driven in transmit states.
- A partial fill (fewer than PKT_BYTES bytes) waits indefinitely in FILL; only abort or reset clears it.
- Reset mid-transmit: dout is forced to 0 immediately (async). No pkt_done is generated.

Optional Feature:
- Macro: PKT_TX_CRC_EN.
- Defined: a CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) is computed over the payload bits.
  - The CRC register updates on each payload bit as it is driven.
  - After the last payload bit, the CRC state sends the 8 CRC bits MSB-first, then finishes with the pkt_done step.
  - Total bit_en count at defaults = 89.
- Undefined: the CRC state and logic are absent; PAY ends the packet directly.

Test Plan:
- Reset, then 8 bytes 8'h01..8'h08 on byte_vld, then continuous bit_en every 4 clk -> dout sequence is 8'hAA, 8'hD3, then 64'h0102030405060708, MSB-first, then 0. pkt_done pulses once after the 81st bit_en; busy is high throughout.
- After 8 bytes are loaded, send byte_vld with 8'hFF during PAY -> ovf pulses once; the transmitted payload is unchanged.
- Load 5 bytes, assert abort, then load 8 bytes 8'hF0 -> the transmitted payload is 64'hF0F0F0F0F0F0F0F0 with no stale bytes; the aborted fill produces no pkt_done.
- Assert abort in the cycle of the 20th bit_en -> dout=0 and busy=0 on the next clk; no pkt_done; byte_rdy=1.
- Hold bit_en low for 100 clk while in ARM -> dout stays 0, busy=1, state does not advance; the first bit_en then starts the preamble.
- With PKT_TX_CRC_EN defined, payload 64'h3132333435363738 ("12345678") -> the 8 bits after the payload equal the CRC-8/0x07 of those bytes. The bench computes it with a reference model; pkt_done follows after the 89th bit_en.
